// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers.
// One PREP cycle, 32 shift-add / shift-subtract cycles, one sign-fix cycle.
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] readRs,
  input  logic [WIDTH-1:0] readRt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = 5;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } stateT;

  stateT          state;
  stateT          nextState;
  logic [CW-1:0]  cnt;
  logic           opDiv;
  logic           opSigned;
  logic           negRes;
  logic           negRem;
  logic           divZero;
  logic [W-1:0]   opA;
  logic [W-1:0]   opB;
  logic [W-1:0]   accHi;
  logic [W-1:0]   accLo;

  logic           idleLike;
  logic           startOk;
  logic           isMulDiv;
  logic           accept;

  logic [W-1:0]   absA;
  logic [W-1:0]   absB;
  logic [W:0]     mulSum;
  logic [W:0]     divShift;
  logic           divGe;
  logic [W-1:0]   divRem;
  logic [W2-1:0]  prodFix;
  logic [W-1:0]   quoFix;
  logic [W-1:0]   remFix;
  logic [W-1:0]   fixHi;
  logic [W-1:0]   fixLo;

  assign idleLike = (state == IDLE) || (state == DONE);
  assign startOk  = idleLike && start && !flush;
  assign isMulDiv = (funct == F_MULT) || (funct == F_MULTU) ||
                    (funct == F_DIV)  || (funct == F_DIVU);
  assign accept   = startOk && isMulDiv;

  assign busy = (state == PREP) || (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) nextState = PREP;
      end
      DONE: begin
        if (accept) nextState = PREP;
        else        nextState = IDLE;
      end
      PREP: nextState = flush ? IDLE : CALC;
      CALC: begin
        if (flush)                    nextState = IDLE;
        else if (cnt == CW'(W - 1))   nextState = FIX;
      end
      FIX:  nextState = flush ? IDLE : DONE;
      default: nextState = IDLE;
    endcase
  end

  assign absA = (opSigned && opA[W-1]) ? W'(~opA + W'(1)) : opA;
  assign absB = (opSigned && opB[W-1]) ? W'(~opB + W'(1)) : opB;

  // Multiply step: add multiplicand into upper half when LSB of multiplier is set, then shift right
  assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : (W + 1)'(0));

  // Restoring divide step: shift dividend bit into remainder, subtract divisor if it fits
  assign divShift = {accHi, accLo[W-1]};
  assign divGe    = divShift >= {1'b0, opB};
  assign divRem   = divGe ? W'(divShift[W-1:0] - opB) : divShift[W-1:0];

  // Sign correction and divide-by-zero result
  assign prodFix = negRes ? W2'(~{accHi, accLo} + W2'(1)) : {accHi, accLo};
  assign quoFix  = negRes ? W'(~accLo + W'(1)) : accLo;
  assign remFix  = negRem ? W'(~accHi + W'(1)) : accHi;
  assign fixHi   = opDiv ? (divZero ? opA : remFix)   : prodFix[W2-1:W];
  assign fixLo   = opDiv ? (divZero ? '1  : quoFix)   : prodFix[W-1:0];

  // Operand capture and iterative datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      opDiv    <= 1'b0;
      opSigned <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      divZero  <= 1'b0;
      opA      <= '0;
      opB      <= '0;
      accHi    <= '0;
      accLo    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            opDiv    <= funct[1];
            opSigned <= ~funct[0];
            opA      <= readRs;
            opB      <= readRt;
          end
        end
        PREP: begin
          negRes  <= opSigned && (opA[W-1] ^ opB[W-1]);
          negRem  <= opSigned && opA[W-1];
          divZero <= opDiv && (opB == '0);
          cnt     <= '0;
          accHi   <= '0;
          // opB becomes the multiplicand or divisor; opA keeps the raw dividend
          if (opDiv) begin
            accLo <= absA;
            opB   <= absB;
          end else begin
            accLo <= absB;
            opB   <= absA;
          end
        end
        CALC: begin
          cnt <= CW'(cnt + CW'(1));
          if (opDiv) begin
            accHi <= divRem;
            accLo <= {accLo[W-2:0], divGe};
          end else begin
            accHi <= mulSum[W:1];
            accLo <= {mulSum[0], accLo[W-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX && !flush) begin
      hi <= fixHi;
      lo <= fixLo;
    end else if (startOk && funct == F_MTHI) begin
      hi <= readRs;
    end else if (startOk && funct == F_MTLO) begin
      lo <= readRs;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and random checks of muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] readRs;
  logic [31:0] readRt;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic [5:0]  ops [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct  (funct),
    .readRs (readRs),
    .readRt (readRt),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial begin
    #1ms;
    $display("FAIL timeout: observed no end of test, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of one instruction, from plain integer arithmetic
  task automatic model(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    longint      p;
    logic [63:0] pu;
    int          q;
    int          r;
    case (f)
      F_MULT: begin
        p   = longint'($signed(rs)) * longint'($signed(rt));
        mHi = p[63:32];
        mLo = p[31:0];
      end
      F_MULTU: begin
        pu  = {32'd0, rs} * {32'd0, rt};
        mHi = pu[63:32];
        mLo = pu[31:0];
      end
      F_DIV: begin
        if (rt == 32'd0) begin
          mLo = 32'hFFFFFFFF;
          mHi = rs;
        end else if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) begin
          mLo = 32'h80000000;
          mHi = 32'd0;
        end else begin
          q   = $signed(rs) / $signed(rt);
          r   = $signed(rs) % $signed(rt);
          mLo = q;
          mHi = r;
        end
      end
      F_DIVU: begin
        if (rt == 32'd0) begin
          mLo = 32'hFFFFFFFF;
          mHi = rs;
        end else begin
          mLo = rs / rt;
          mHi = rs % rt;
        end
      end
      F_MTHI:  mHi = rs;
      F_MTLO:  mLo = rs;
      default: ;
    endcase
  endtask

  // Present a start for one edge; returns at the negedge of the first busy cycle
  task automatic launch(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    start  = 1'b1;
    funct  = f;
    readRs = rs;
    readRt = rt;
    @(negedge clk);
    start  = 1'b0;
    readRs = $urandom;
    readRt = $urandom;
    model(f, rs, rt);
  endtask

  // From the first busy cycle: 34 busy cycles, then one done cycle with the result
  task automatic waitResult(input string tag);
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".done"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    chk({tag, ".donePulse"}, 32'(done), 32'd1);
    chk({tag, ".busyDone"},  32'(busy), 32'd0);
    chk({tag, ".hi"}, hi, mHi);
    chk({tag, ".lo"}, lo, mLo);
  endtask

  task automatic runOp(input string tag, input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    launch(f, rs, rt);
    waitResult(tag);
  endtask

  task automatic idleCheck(input string tag);
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".hi"}, hi, mHi);
    chk({tag, ".lo"}, lo, mLo);
  endtask

  initial begin
    logic [5:0]  f;
    logic [31:0] rs;
    logic [31:0] rt;

    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct  = 6'd0;
    readRs = '0;
    readRt = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);
    rst_n = 1'b1;

    // Directed corner cases with literal expectations
    runOp("multNeg", F_MULT, 32'hFFFFFFFD, 32'd7);
    chk("multNeg.hiConst", hi, 32'hFFFFFFFF);
    chk("multNeg.loConst", lo, 32'hFFFFFFEB);
    idleCheck("afterMult");
    runOp("multuMax", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multuMax.hiConst", hi, 32'hFFFFFFFE);
    chk("multuMax.loConst", lo, 32'h00000001);
    runOp("divNeg", F_DIV, 32'hFFFFFFF9, 32'd2);
    chk("divNeg.loConst", lo, 32'hFFFFFFFD);
    chk("divNeg.hiConst", hi, 32'hFFFFFFFF);
    runOp("divuZero", F_DIVU, 32'd100, 32'd0);
    chk("divuZero.loConst", lo, 32'hFFFFFFFF);
    chk("divuZero.hiConst", hi, 32'd100);
    runOp("divOvf", F_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("divOvf.loConst", lo, 32'h80000000);
    chk("divOvf.hiConst", hi, 32'd0);
    runOp("divZeroNeg", F_DIV, 32'hFFFFFF9C, 32'd0);
    runOp("divNegDivisor", F_DIV, 32'd17, 32'hFFFFFFFB);

    // Random operations with occasional zero or small divisors
    for (int i = 0; i < 24; i++) begin
      f  = ops[$urandom_range(0, 3)];
      rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rt = 32'd0;
        1, 2:    rt = 32'($urandom_range(1, 20));
        3:       rt = -32'($urandom_range(1, 20));
        default: rt = $urandom;
      endcase
      runOp("rand", f, rs, rt);
    end
    idleCheck("afterRand");

    // MTHI / MTLO single-edge writes
    @(negedge clk);
    start = 1'b1; funct = F_MTHI; readRs = $urandom;
    model(F_MTHI, readRs, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("mthi.hi", hi, mHi);
    chk("mthi.lo", lo, mLo);
    chk("mthi.busy", 32'(busy), 32'd0);
    chk("mthi.done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b1; funct = F_MTLO; readRs = $urandom;
    model(F_MTLO, readRs, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("mtlo.lo", lo, mLo);
    chk("mtlo.hi", hi, mHi);

    // Invalid funct and flush-with-start are both ignored
    @(negedge clk);
    start = 1'b1; funct = 6'b100000; readRs = $urandom;
    @(negedge clk);
    start = 1'b0;
    chk("invalid.busy", 32'(busy), 32'd0);
    idleCheck("invalid");
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct = F_MTHI; readRs = ~mHi;
    @(negedge clk);
    funct = F_MULT;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flushStart.busy", 32'(busy), 32'd0);
    chk("flushStart.hi", hi, mHi);
    idleCheck("flushStart");

    // Flush mid-multiply, then MTLO
    @(negedge clk);
    start = 1'b1; funct = F_MULT; readRs = 32'h00012345; readRt = 32'h00067890;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 10; k++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushMid.busy", 32'(busy), 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("flushMid.noDone", 32'(done), 32'd0);
    end
    chk("flushMid.hi", hi, mHi);
    chk("flushMid.lo", lo, mLo);
    @(negedge clk);
    start = 1'b1; funct = F_MTLO; readRs = 32'h12345678;
    model(F_MTLO, readRs, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("flushMtlo.lo", lo, 32'h12345678);
    chk("flushMtlo.hi", hi, mHi);

    // Start while busy ignored; back-to-back start in DONE accepted
    launch(F_DIVU, 32'd1000003, 32'd97);
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      chk("b2bDivu.busy", 32'(busy), 32'd1);
      if (k == 5) begin
        start = 1'b1; funct = F_MULT; readRs = 32'd3; readRt = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2bDivu.done", 32'(done), 32'd1);
    chk("b2bDivu.hi", hi, mHi);
    chk("b2bDivu.lo", lo, mLo);
    start = 1'b1; funct = F_MULT; readRs = 32'h12345678; readRt = 32'h9ABCDEF0;
    model(F_MULT, readRs, readRt);
    @(negedge clk);
    start = 1'b0;
    waitResult("b2bMult");

    // Asynchronous reset mid-calculation, then normal operation
    launch(F_DIV, $urandom, 32'($urandom_range(1, 1000)));
    for (int k = 2; k <= 20; k++) @(negedge clk);
    chk("rstMid.busyBefore", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstMid.busy", 32'(busy), 32'd0);
    chk("rstMid.done", 32'(done), 32'd0);
    chk("rstMid.hi", hi, 32'd0);
    chk("rstMid.lo", lo, 32'd0);
    mHi = '0;
    mLo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idleCheck("afterRst");
    runOp("postRst", F_MULTU, $urandom, $urandom);
    runOp("postRstDiv", F_DIV, $urandom, -32'd13);
    idleCheck("end");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 funct  input  6  op code: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011; other values are no-ops.
REQ-006 readRs  input  32  multiplicand / dividend / MTHI or MTLO source.
REQ-007 readRt  input  32  multiplier / divisor.
REQ-008 flush  input  1  abort any in-flight operation.
REQ-009 busy  output  1  high in PREP, CALC and FIX; pipeline stall for MFHI/MFLO and new muldiv ops.
REQ-010 done  output  1  one-cycle pulse when HI/LO hold a new mult/div result.
REQ-011 hi  output  32  HI register.
REQ-012 lo  output  32  LO register.

Function
REQ-013 FSM states are IDLE, PREP, CALC, FIX and DONE, with no other states.
REQ-014 IDLE/DONE with start=1, flush=0 and funct in {MULT, MULTU, DIV, DIVU}: latch op, readRs and readRt, then go to PREP.
REQ-015 IDLE/DONE with start=1, flush=0 and funct=MTHI (MTLO): hi (lo) <= readRs on that edge, the other register is unchanged, next state IDLE, done stays 0.
REQ-016 PREP takes 1 cycle.
  - Signed ops: store absolute values of the operands and the result sign flags.
  - Unsigned ops: store the operands as-is.
REQ-017 CALC takes exactly 32 cycles, counted by a 5-bit counter.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 1 quotient bit per cycle.
REQ-018 FIX takes 1 cycle.
  - Apply two's-complement negation: product if the signs differ; quotient if the signs differ; remainder if the dividend is negative.
  - Write hi/lo on the edge that leaves FIX, then go to DONE.
REQ-019 Mult result: hi = product[63:32], lo = product[31:0].
REQ-020 Div result: lo = quotient, hi = remainder, truncating toward zero.
REQ-021 Divisor = 0: lo = 32'hFFFFFFFF and hi = original readRs, for both DIV and DIVU, with the same latency.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF gives lo = 32'h80000000 and hi = 0, with no exception.
REQ-023 Latency: start accepted at edge E0 -> busy high for cycles E0+1..E0+34, hi/lo update at edge E0+35, done high during cycle E0+35 only.
REQ-024 In DONE, busy = 0 and a new start is accepted (back-to-back ops); with no start, next state is IDLE.
REQ-025 start while busy is ignored; the operation in flight is not disturbed.
REQ-026 flush in PREP, CALC or FIX: return to IDLE on the next edge, hi/lo unchanged, no done pulse.
REQ-027 flush together with start in IDLE/DONE: flush wins, nothing is accepted (including MTHI/MTLO).
REQ-028 Invalid funct with start: no state change.
REQ-029 busy and done are decoded from the state register only, with no combinational path from inputs.

Reset
REQ-030 rst_n low at any time, including mid-CALC, forces state IDLE, counter 0, hi = 0, lo = 0, busy = 0 and done = 0 immediately, without waiting for a clock edge.
REQ-031 After rst_n deasserts, the first start is accepted on the first rising edge at which it is sampled high.

Verification
REQ-032 MULT readRs=32'hFFFFFFFD (-3), readRt=7 -> done at E0+35; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-033 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-034 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100/0 -> lo=32'hFFFFFFFF, hi=100.
REQ-035 MULT in flight with flush at cycle E0+10 -> IDLE at E0+11, hi/lo keep their prior values, no done; a following MTLO 32'h12345678 -> lo=32'h12345678 one edge later.
REQ-036 DIVU started, a second start issued at E0+5, then DONE with start=MULT -> the second start is ignored and the MULT is accepted in DONE, busy again at E0+36.
REQ-037 rst_n pulsed low at E0+20 during CALC -> hi=lo=0, busy=0 asynchronously; the next op then completes normally.
